// File: rtl/vid2is_pkg.sv
// Shared definitions for the clocked-video-input packet sequencer.
//   state_e     : sequencer FSM states
//   CTRL_TYPE   : packet type nibble of the Avalon-ST Video control packet
//   VID_TYPE    : packet type nibble of the Avalon-ST Video video packet
//   CTRL_BODY_LEN : number of control packet body symbols
//   ctrl_nibble : selects the control packet body symbol for a given index
package vid2is_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CTRL_HDR  = 3'd1,
        ST_CTRL_BODY = 3'd2,
        ST_VID_HDR   = 3'd3,
        ST_VIDEO     = 3'd4,
        ST_CLOSE     = 3'd5,
        ST_SKIP      = 3'd6
    } state_e;

    localparam logic [3:0] CTRL_TYPE     = 4'hF;
    localparam logic [3:0] VID_TYPE      = 4'h0;
    localparam logic [3:0] CTRL_BODY_LEN = 4'd9;

    // Body symbol idx: width nibbles MSB first, height nibbles MSB first, then
    // the interlace/field descriptor.
    function automatic logic [3:0] ctrl_nibble(input logic [3:0]  idx,
                                               input logic [15:0] w,
                                               input logic [15:0] h,
                                               input logic        il,
                                               input logic        fld);
        logic [3:0] n;
        case (idx)
            4'd0:    n = w[15:12];
            4'd1:    n = w[11:8];
            4'd2:    n = w[7:4];
            4'd3:    n = w[3:0];
            4'd4:    n = h[15:12];
            4'd5:    n = h[11:8];
            4'd6:    n = h[7:4];
            4'd7:    n = h[3:0];
            4'd8:    n = {il, fld, 2'b00};
            default: n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vid2is_dim_counter.sv
// Frame dimension measurement for the packet sequencer.
// Counts samples per line and lines per frame into shadow registers and
// publishes them on commit.
//   clk, rst       : clock, async active-high reset
//   frame_start_i  : clear per-frame counters and shadows
//   sample_i       : one accepted active sample/beat
//   eol_i          : qualifies sample_i as the last of a line
//   hd_i           : 1 = one beat per pixel, 0 = SD (two samples per pixel)
//   commit_i       : copy shadows to outputs and mark dimensions valid
//   invalidate_i   : clear dims_valid_o (takes priority over commit_i)
//   width_o, height_o, dims_valid_o : published dimensions
module vid2is_dim_counter
    import vid2is_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start_i,
    input  logic                 sample_i,
    input  logic                 eol_i,
    input  logic                 hd_i,
    input  logic                 commit_i,
    input  logic                 invalidate_i,
    output logic [CNT_WIDTH-1:0] width_o,
    output logic [CNT_WIDTH-1:0] height_o,
    output logic                 dims_valid_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] shadow_w_q, shadow_w_d;
    logic [CNT_WIDTH-1:0] shadow_h_q, shadow_h_d;
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic [CNT_WIDTH-1:0] height_q, height_d;
    logic                 dims_valid_q, dims_valid_d;
    logic [CNT_WIDTH-1:0] line_inc_s;
    logic [CNT_WIDTH-1:0] height_inc_s;

    // Saturating counters, shadow capture at end of line, and commit
    always_comb begin
        line_inc_s   = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + CNT_ONE;
        height_inc_s = (shadow_h_q == CNT_MAX) ? CNT_MAX : shadow_h_q + CNT_ONE;
        line_cnt_d   = line_cnt_q;
        shadow_w_d   = shadow_w_q;
        shadow_h_d   = shadow_h_q;
        width_d      = width_q;
        height_d     = height_q;
        dims_valid_d = dims_valid_q;

        if (frame_start_i) begin
            line_cnt_d = '0;
            shadow_w_d = '0;
            shadow_h_d = '0;
        end else if (sample_i && eol_i) begin
            line_cnt_d = '0;
            // SD carries two samples per pixel, so the pixel width is half
            shadow_w_d = hd_i ? line_inc_s : (line_inc_s >> 1);
            shadow_h_d = height_inc_s;
        end else if (sample_i) begin
            line_cnt_d = line_inc_s;
        end else begin
            line_cnt_d = line_cnt_q;
        end

        if (commit_i) begin
            width_d  = shadow_w_q;
            height_d = shadow_h_q;
        end else begin
            width_d  = width_q;
            height_d = height_q;
        end

        if (invalidate_i) begin
            dims_valid_d = 1'b0;
        end else if (commit_i) begin
            dims_valid_d = 1'b1;
        end else begin
            dims_valid_d = dims_valid_q;
        end
    end

    // Dimension state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt_q   <= '0;
            shadow_w_q   <= '0;
            shadow_h_q   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            dims_valid_q <= 1'b0;
        end else begin
            line_cnt_q   <= line_cnt_d;
            shadow_w_q   <= shadow_w_d;
            shadow_h_q   <= shadow_h_d;
            width_q      <= width_d;
            height_q     <= height_d;
            dims_valid_q <= dims_valid_d;
        end
    end

    assign width_o      = width_q;
    assign height_o     = height_q;
    assign dims_valid_o = dims_valid_q;

endmodule

// File: rtl/vid2is_packet_sequencer.sv
// Packet sequencer in front of the clocked-video-input write buffer.
// Emits per frame an optional control packet (when dimensions are known)
// and a video packet, closes each frame with early_eop, measures dimensions
// and drops whole frames while the downstream FIFO is almost full.
//   clk, rst            : clock, async active-high reset
//   enable              : accept a new frame at the next vid_sof
//   hd_sdn, interlaced, vid_field : frame attributes sampled at vid_sof
//   vid_sof, vid_valid, vid_data, vid_eol : decoded video stream
//   fifo_almost_full    : drop the starting frame when high
//   status_clear        : clears overflow and sync_error
//   wrreq_out, data_out, packet_out, convert_out, hd_sdn_out, early_eop_out :
//                         registered write-buffer controls
//   frame_width, frame_height, dims_valid : last committed dimensions
//   overflow, sync_error : sticky status flags
module vid2is_packet_sequencer
    import vid2is_pkg::*;
#(
    parameter int BPS                     = 10,
    parameter int NUMBER_OF_COLOUR_PLANES = 2,
    parameter int DATA_WIDTH              = BPS * NUMBER_OF_COLOUR_PLANES,
    parameter int CNT_WIDTH               = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  hd_sdn,
    input  logic                  interlaced,
    input  logic                  vid_sof,
    input  logic                  vid_valid,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  vid_eol,
    input  logic                  vid_field,
    input  logic                  fifo_almost_full,
    input  logic                  status_clear,
    output logic                  wrreq_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  packet_out,
    output logic                  convert_out,
    output logic                  hd_sdn_out,
    output logic                  early_eop_out,
    output logic [CNT_WIDTH-1:0]  frame_width,
    output logic [CNT_WIDTH-1:0]  frame_height,
    output logic                  dims_valid,
    output logic                  overflow,
    output logic                  sync_error
);

    state_e                state_q, state_d;
    logic [3:0]            body_cnt_q, body_cnt_d;
    logic                  mode_q, mode_d, il_q, il_d, fld_q, fld_d;
    logic                  samp_hd_q, samp_hd_d, samp_il_q, samp_il_d, samp_fld_q, samp_fld_d;
    logic                  ovf_q, ovf_d, serr_q, serr_d;
    logic                  wrreq_q, wrreq_d, packet_q, packet_d, convert_q, convert_d;
    logic                  hd_out_q, hd_out_d, eop_q, eop_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cur_hd_s, cur_il_s, cur_fld_s;
    logic                  decide_s, mode_change_s, dims_eff_s, ovf_set_s, serr_set_s;
    logic                  dims_valid_s;
    logic [CNT_WIDTH-1:0]  width_s, height_s;

    // Attributes of the starting frame: live at vid_sof, captured copy when the
    // decision is deferred to CLOSE
    always_comb begin
        if (vid_sof) begin
            samp_hd_d  = hd_sdn;
            samp_il_d  = interlaced;
            samp_fld_d = vid_field;
            cur_hd_s   = hd_sdn;
            cur_il_s   = interlaced;
            cur_fld_s  = vid_field;
        end else begin
            samp_hd_d  = samp_hd_q;
            samp_il_d  = samp_il_q;
            samp_fld_d = samp_fld_q;
            cur_hd_s   = samp_hd_q;
            cur_il_s   = samp_il_q;
            cur_fld_s  = samp_fld_q;
        end
    end

    // FSM next state, frame-start decision and sticky status flags
    always_comb begin
        state_d    = state_q;
        body_cnt_d = body_cnt_q;
        decide_s   = 1'b0;
        case (state_q)
            ST_IDLE:      decide_s = vid_sof && enable;
            ST_CTRL_HDR: begin
                state_d    = ST_CTRL_BODY;
                body_cnt_d = 4'd0;
            end
            ST_CTRL_BODY: begin
                if (body_cnt_q == (CTRL_BODY_LEN - 4'd1)) begin
                    state_d = ST_VID_HDR;
                end else begin
                    body_cnt_d = body_cnt_q + 4'd1;
                end
            end
            ST_VID_HDR:   state_d = ST_VIDEO;
            ST_VIDEO: begin
                if (vid_sof) begin
                    state_d = ST_CLOSE;
                end else begin
                    state_d = ST_VIDEO;
                end
            end
            ST_CLOSE: begin
                if (enable) begin
                    decide_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (vid_sof && enable) begin
                    decide_s = 1'b1;
                end else if (vid_sof) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            default:      state_d = ST_IDLE;
        endcase

        // A mode change invalidates dimensions before the control-packet
        // decision; in CLOSE the commit of this cycle already counts as valid.
        mode_change_s = decide_s && (cur_hd_s != mode_q);
        dims_eff_s    = (dims_valid_s || (state_q == ST_CLOSE)) && !mode_change_s;
        mode_d        = mode_q;
        il_d          = il_q;
        fld_d         = fld_q;
        ovf_set_s     = 1'b0;
        if (decide_s) begin
            mode_d = cur_hd_s;
            il_d   = cur_il_s;
            fld_d  = cur_fld_s;
            if (fifo_almost_full) begin
                state_d   = ST_SKIP;
                ovf_set_s = 1'b1;
            end else if (dims_eff_s) begin
                state_d = ST_CTRL_HDR;
            end else begin
                state_d = ST_VID_HDR;
            end
        end else begin
            ovf_set_s = 1'b0;
        end

        serr_set_s = vid_valid && ((state_q == ST_IDLE) || (state_q == ST_CTRL_HDR) ||
                                   (state_q == ST_CTRL_BODY) || (state_q == ST_VID_HDR));
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (status_clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (serr_set_s) begin
            serr_d = 1'b1;
        end else if (status_clear) begin
            serr_d = 1'b0;
        end else begin
            serr_d = serr_q;
        end
    end

    // Write-buffer output mux, registered below
    always_comb begin
        wrreq_d   = 1'b0;
        data_d    = '0;
        packet_d  = 1'b0;
        convert_d = 1'b1;
        hd_out_d  = 1'b0;
        eop_d     = 1'b0;
        case (state_q)
            ST_CTRL_HDR: begin
                wrreq_d  = 1'b1;
                packet_d = 1'b1;
                data_d   = DATA_WIDTH'(CTRL_TYPE);
            end
            ST_CTRL_BODY: begin
                wrreq_d = 1'b1;
                data_d  = DATA_WIDTH'(ctrl_nibble(body_cnt_q, 16'(width_s), 16'(height_s),
                                                  il_q, fld_q));
            end
            ST_VID_HDR: begin
                wrreq_d  = 1'b1;
                packet_d = 1'b1;
                data_d   = DATA_WIDTH'(VID_TYPE);
            end
            ST_VIDEO: begin
                wrreq_d  = vid_valid;
                data_d   = vid_data;
                hd_out_d = mode_q;
            end
            ST_CLOSE:    eop_d = 1'b1;
            default:     eop_d = 1'b0;
        endcase
    end

    // State, frame attribute, status and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            body_cnt_q <= 4'd0;
            mode_q     <= 1'b0;
            il_q       <= 1'b0;
            fld_q      <= 1'b0;
            samp_hd_q  <= 1'b0;
            samp_il_q  <= 1'b0;
            samp_fld_q <= 1'b0;
            ovf_q      <= 1'b0;
            serr_q     <= 1'b0;
            wrreq_q    <= 1'b0;
            data_q     <= '0;
            packet_q   <= 1'b0;
            convert_q  <= 1'b1;
            hd_out_q   <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            body_cnt_q <= body_cnt_d;
            mode_q     <= mode_d;
            il_q       <= il_d;
            fld_q      <= fld_d;
            samp_hd_q  <= samp_hd_d;
            samp_il_q  <= samp_il_d;
            samp_fld_q <= samp_fld_d;
            ovf_q      <= ovf_d;
            serr_q     <= serr_d;
            wrreq_q    <= wrreq_d;
            data_q     <= data_d;
            packet_q   <= packet_d;
            convert_q  <= convert_d;
            hd_out_q   <= hd_out_d;
            eop_q      <= eop_d;
        end
    end

    vid2is_dim_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dim (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (state_q == ST_VID_HDR),
        .sample_i      ((state_q == ST_VIDEO) && vid_valid),
        .eol_i         (vid_eol),
        .hd_i          (mode_q),
        .commit_i      (state_q == ST_CLOSE),
        .invalidate_i  (mode_change_s),
        .width_o       (width_s),
        .height_o      (height_s),
        .dims_valid_o  (dims_valid_s)
    );

    assign wrreq_out     = wrreq_q;
    assign data_out      = data_q;
    assign packet_out    = packet_q;
    assign convert_out   = convert_q;
    assign hd_sdn_out    = hd_out_q;
    assign early_eop_out = eop_q;
    assign frame_width   = width_s;
    assign frame_height  = height_s;
    assign dims_valid    = dims_valid_s;
    assign overflow      = ovf_q;
    assign sync_error    = serr_q;

endmodule
